// File: rtl/orb_pkg.sv
// rtl/orb_pkg.sv - shared state enum and constants for the ORB frame sequencer
package orb_pkg;

  localparam int ORB_NUM_LEVELS = 6;
  localparam int ORB_MASK_BITS  = 32;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_RESET,
    SEQ_STREAM,
    SEQ_DRAIN,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/raster_coord_counter.sv
// rtl/raster_coord_counter.sv - raster x/y counter with wrap and last-pixel flag
module raster_coord_counter #(
  parameter int COORD_BITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [COORD_BITS-1:0] width,
  input  logic [COORD_BITS-1:0] height,
  output logic [COORD_BITS-1:0] x,
  output logic [COORD_BITS-1:0] y,
  output logic                  last
);

  logic [COORD_BITS-1:0] x_q, x_d;
  logic [COORD_BITS-1:0] y_q, y_d;
  logic                  x_end, y_end;

  always_comb begin
    x_end = (x_q == width - COORD_BITS'(1));
    y_end = (y_q == height - COORD_BITS'(1));
    x_d   = x_q;
    y_d   = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + COORD_BITS'(1);
      end else begin
        x_d = x_q + COORD_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_end & y_end;

endmodule

// File: rtl/orb_frame_sequencer.sv
// rtl/orb_frame_sequencer.sv - frame start/reset/stream/drain controller for the ORB pipeline
// Optional per-level feature budget is enabled with ORB_SEQ_BUDGET_EN.
module orb_frame_sequencer
  import orb_pkg::*;
#(
  parameter int LUMA_BITS  = 8,
  parameter int COORD_BITS = 10,
  parameter int NUM_LEVELS = ORB_NUM_LEVELS,
  parameter int COUNT_BITS = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_start,
  input  logic [COORD_BITS-1:0]               r_width,
  input  logic [COORD_BITS-1:0]               r_height,
  input  logic [COUNT_BITS-1:0]               r_budget,
  input  logic [ORB_MASK_BITS*NUM_LEVELS-1:0] r_masks,
  input  logic                                in_src_valid,
  input  logic [LUMA_BITS-1:0]                in_src_pixel,
  output logic                                out_src_ready,
  output logic                                out_pipe_valid,
  output logic [LUMA_BITS-1:0]                out_pipe_pixel,
  output logic [COORD_BITS-1:0]               out_pipe_x,
  output logic [COORD_BITS-1:0]               out_pipe_y,
  output logic                                out_begin_frame_reset,
  input  logic                                in_frame_reset_complete,
  input  logic                                in_frame_end,
  input  logic [NUM_LEVELS-1:0]               in_corner_count_increments,
  output logic [ORB_MASK_BITS*NUM_LEVELS-1:0] out_masks,
  output logic                                out_busy,
  output logic                                out_frame_done
);

  seq_state_t            state_q, state_d;
  logic [COORD_BITS-1:0] width_q, width_d, height_q, height_d;
  logic                  begin_q, begin_d;
  logic                  sticky_q, sticky_d;
  logic                  pipe_valid_q, pipe_valid_d;
  logic [LUMA_BITS-1:0]  pipe_pixel_q, pipe_pixel_d;
  logic [COORD_BITS-1:0] pipe_x_q, pipe_x_d, pipe_y_q, pipe_y_d;
  logic                  src_ready, beat, clear_frame;
  logic [COORD_BITS-1:0] cur_x, cur_y;
  logic                  cur_last;

  raster_coord_counter #(.COORD_BITS(COORD_BITS)) u_raster (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_frame),
    .advance (beat),
    .width   (width_q),
    .height  (height_q),
    .x       (cur_x),
    .y       (cur_y),
    .last    (cur_last)
  );

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    height_d     = height_q;
    begin_d      = 1'b0;
    sticky_d     = sticky_q;
    clear_frame  = 1'b0;
    src_ready    = (state_q == SEQ_STREAM);
    beat         = src_ready & in_src_valid;
    pipe_valid_d = beat;
    pipe_pixel_d = beat ? in_src_pixel : pipe_pixel_q;
    pipe_x_d     = beat ? cur_x : pipe_x_q;
    pipe_y_d     = beat ? cur_y : pipe_y_q;
    case (state_q)
      SEQ_IDLE: begin
        if (in_start && (r_width != '0) && (r_height != '0)) begin
          width_d     = r_width;
          height_d    = r_height;
          begin_d     = 1'b1;
          sticky_d    = 1'b0;
          clear_frame = 1'b1;
          state_d     = SEQ_RESET;
        end
      end
      // A completion coinciding with our own reset pulse is stale.
      SEQ_RESET:  if (in_frame_reset_complete && !begin_q) state_d = SEQ_STREAM;
      SEQ_STREAM: begin
        if (in_frame_end) sticky_d = 1'b1;
        if (beat && cur_last) state_d = SEQ_DRAIN;
      end
      SEQ_DRAIN:  if (in_frame_end || sticky_q) state_d = SEQ_DONE;
      SEQ_DONE:   state_d = SEQ_IDLE;
      default:    state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SEQ_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      begin_q      <= 1'b0;
      sticky_q     <= 1'b0;
      pipe_valid_q <= 1'b0;
      pipe_pixel_q <= '0;
      pipe_x_q     <= '0;
      pipe_y_q     <= '0;
    end else begin
      state_q      <= state_d;
      width_q      <= width_d;
      height_q     <= height_d;
      begin_q      <= begin_d;
      sticky_q     <= sticky_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_pixel_q <= pipe_pixel_d;
      pipe_x_q     <= pipe_x_d;
      pipe_y_q     <= pipe_y_d;
    end
  end

  assign out_src_ready         = src_ready;
  assign out_pipe_valid        = pipe_valid_q;
  assign out_pipe_pixel        = pipe_pixel_q;
  assign out_pipe_x            = pipe_x_q;
  assign out_pipe_y            = pipe_y_q;
  assign out_begin_frame_reset = begin_q;
  assign out_busy              = (state_q != SEQ_IDLE);
  assign out_frame_done        = (state_q == SEQ_DONE);

`ifdef ORB_SEQ_BUDGET_EN
  logic [COUNT_BITS-1:0]               count_q [NUM_LEVELS];
  logic [COUNT_BITS-1:0]               count_d [NUM_LEVELS];
  logic [ORB_MASK_BITS*NUM_LEVELS-1:0] masks_c;

  always_comb begin
    masks_c = r_masks;
    for (int l = 0; l < NUM_LEVELS; l++) begin
      count_d[l] = count_q[l];
      if (clear_frame) begin
        count_d[l] = '0;
      end else if (in_corner_count_increments[l] && (count_q[l] != '1)) begin
        count_d[l] = count_q[l] + COUNT_BITS'(1);
      end
      if ((r_budget != '0) && (count_q[l] >= r_budget)) begin
        masks_c[l*ORB_MASK_BITS +: ORB_MASK_BITS] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < NUM_LEVELS; l++) count_q[l] <= '0;
    end else begin
      for (int l = 0; l < NUM_LEVELS; l++) count_q[l] <= count_d[l];
    end
  end

  assign out_masks = masks_c;
`else
  logic unused_budget_inputs;
  assign unused_budget_inputs = ^{in_corner_count_increments, r_budget};
  assign out_masks            = r_masks;
`endif

endmodule

// File: tb/tb_orb_frame_sequencer.sv
// tb/tb_orb_frame_sequencer.sv - randomized self-checking bench for orb_frame_sequencer
module tb_orb_frame_sequencer;

  localparam int LB = 8;
  localparam int CB = 10;
  localparam int NL = 6;
  localparam int KB = 16;
  localparam int MW = 32 * NL;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_start;
  logic [CB-1:0] r_width, r_height;
  logic [KB-1:0] r_budget;
  logic [MW-1:0] r_masks;
  logic          in_src_valid;
  logic [LB-1:0] in_src_pixel;
  logic          out_src_ready, out_pipe_valid;
  logic [LB-1:0] out_pipe_pixel;
  logic [CB-1:0] out_pipe_x, out_pipe_y;
  logic          out_begin_frame_reset;
  logic          in_frame_reset_complete, in_frame_end;
  logic [NL-1:0] in_corner_count_increments;
  logic [MW-1:0] out_masks;
  logic          out_busy, out_frame_done;

  int checks = 0;
  int failures = 0;

  orb_frame_sequencer #(.LUMA_BITS(LB), .COORD_BITS(CB), .NUM_LEVELS(NL), .COUNT_BITS(KB)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .in_start                   (in_start),
    .r_width                    (r_width),
    .r_height                   (r_height),
    .r_budget                   (r_budget),
    .r_masks                    (r_masks),
    .in_src_valid               (in_src_valid),
    .in_src_pixel               (in_src_pixel),
    .out_src_ready              (out_src_ready),
    .out_pipe_valid             (out_pipe_valid),
    .out_pipe_pixel             (out_pipe_pixel),
    .out_pipe_x                 (out_pipe_x),
    .out_pipe_y                 (out_pipe_y),
    .out_begin_frame_reset      (out_begin_frame_reset),
    .in_frame_reset_complete    (in_frame_reset_complete),
    .in_frame_end               (in_frame_end),
    .in_corner_count_increments (in_corner_count_increments),
    .out_masks                  (out_masks),
    .out_busy                   (out_busy),
    .out_frame_done             (out_frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  MW'(out_busy), MW'(0));
    chk({tag, "_ready"}, MW'(out_src_ready), MW'(0));
    chk({tag, "_valid"}, MW'(out_pipe_valid), MW'(0));
    chk({tag, "_begin"}, MW'(out_begin_frame_reset), MW'(0));
    chk({tag, "_done"},  MW'(out_frame_done), MW'(0));
    chk({tag, "_coord"}, MW'({out_pipe_x, out_pipe_y, out_pipe_pixel}), MW'(0));
    chk({tag, "_masks"}, out_masks, r_masks);
  endtask

  // Expected stream is derived from the beat index: x = i mod W, y = i div W.
  task automatic run_frame(input int w, input int h, input int mode, input int sticky_at,
                           input int abort_at);
    int idx, cyc, total;
    logic expect_beat;
    logic [LB-1:0] exp_pix;
    total = w * h;
    r_width  = CB'(w);
    r_height = CB'(h);
    in_start = 1'b1;
    step();
    in_start = 1'b0;
    chk("begin_pulse", MW'(out_begin_frame_reset), MW'(1));
    chk("busy_start", MW'(out_busy), MW'(1));
    in_frame_reset_complete = 1'b1;
    step();
    in_frame_reset_complete = 1'b0;
    chk("begin_one_cycle", MW'(out_begin_frame_reset), MW'(0));
    repeat ($urandom_range(0, 3)) step();
    chk("held_in_reset", MW'(out_src_ready), MW'(0));
    in_frame_reset_complete = 1'b1;
    step();
    in_frame_reset_complete = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < total && cyc < 1000) begin
      chk("ready_in_stream", MW'(out_src_ready), MW'(1));
      case (mode)
        0:       in_src_valid = 1'b1;
        1:       in_src_valid = (cyc % 2 == 0);
        default: in_src_valid = 1'($urandom_range(0, 1));
      endcase
      in_src_pixel = LB'($urandom);
      in_frame_end = (idx == sticky_at);
      expect_beat  = in_src_valid;
      exp_pix      = in_src_pixel;
      step();
      cyc++;
      chk("pipe_valid", MW'(out_pipe_valid), MW'(expect_beat));
      if (expect_beat) begin
        chk("pipe_pixel", MW'(out_pipe_pixel), MW'(exp_pix));
        chk("pipe_x", MW'(out_pipe_x), MW'(idx % w));
        chk("pipe_y", MW'(out_pipe_y), MW'(idx / w));
        idx++;
        if (idx == abort_at) begin
          in_src_valid = 1'b0;
          in_frame_end = 1'b0;
          reset = 1'b0;
          #1;
          chk_idle_outputs("async_reset");
          #2;
          reset = 1'b1;
          step();
          return;
        end
      end
    end
    in_src_valid = 1'b0;
    in_frame_end = 1'b0;
    if (cyc >= 1000) chk("stream_timeout", MW'(0), MW'(1));
    chk("ready_drops", MW'(out_src_ready), MW'(0));
    chk("no_early_done", MW'(out_frame_done), MW'(0));
    if (sticky_at >= 0) begin
      step();
      chk("done_sticky", MW'(out_frame_done), MW'(1));
    end else begin
      repeat (4) begin
        step();
        chk("drain_wait", MW'(out_frame_done), MW'(0));
      end
      in_frame_end = 1'b1;
      step();
      in_frame_end = 1'b0;
      chk("done_after_end", MW'(out_frame_done), MW'(1));
    end
    step();
    chk("done_one_cycle", MW'(out_frame_done), MW'(0));
    chk("idle_after_done", MW'(out_busy), MW'(0));
  endtask

  task automatic budget_test();
    int cnt [NL];
    logic [NL-1:0] s;
    logic [MW-1:0] exp_m;
    r_budget = KB'(3);
    r_masks  = {6{32'($urandom) | 32'h1}};
    r_width  = CB'(2);
    r_height = CB'(1);
    in_start = 1'b1;
    step();
    in_start = 1'b0;
    for (int l = 0; l < NL; l++) cnt[l] = 0;
    for (int c = 0; c < 3; c++) begin
      s = (c < 2) ? NL'($urandom) : '0;
      s[2] = 1'b1;
      in_corner_count_increments = s;
      step();
      in_corner_count_increments = '0;
      exp_m = r_masks;
      for (int l = 0; l < NL; l++) begin
        if (s[l]) cnt[l]++;
`ifdef ORB_SEQ_BUDGET_EN
        if (cnt[l] >= 3) exp_m[l*32 +: 32] = '0;
`endif
      end
      chk("mask_budget", out_masks, exp_m);
    end
    r_budget = '0;
    #1;
    chk("mask_unlimited", out_masks, r_masks);
    r_budget = KB'(3);
    #1;
    in_frame_reset_complete = 1'b1;
    step();
    in_frame_reset_complete = 1'b0;
    in_src_valid = 1'b1;
    repeat (2) step();
    in_src_valid = 1'b0;
    in_frame_end = 1'b1;
    step();
    in_frame_end = 1'b0;
    step();
    chk("budget_frame_idle", MW'(out_busy), MW'(0));
    chk("mask_persist_idle", out_masks, exp_m);
    in_start = 1'b1;
    step();
    in_start = 1'b0;
    chk("mask_cleared_reset", out_masks, r_masks);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b0;
    in_start = 1'b0;
    r_width = '0;
    r_height = '0;
    r_budget = '0;
    r_masks = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in_src_valid = 1'b0;
    in_src_pixel = '0;
    in_frame_reset_complete = 1'b0;
    in_frame_end = 1'b0;
    in_corner_count_increments = '0;
    repeat (2) step();
    chk_idle_outputs("reset_state");
    reset = 1'b1;
    step();

    r_width = CB'(0);
    r_height = CB'(3);
    in_start = 1'b1;
    step();
    in_start = 1'b0;
    chk("zero_w_busy", MW'(out_busy), MW'(0));
    chk("zero_w_begin", MW'(out_begin_frame_reset), MW'(0));
    r_width = CB'(4);
    r_height = CB'(0);
    in_start = 1'b1;
    step();
    in_start = 1'b0;
    chk("zero_h_busy", MW'(out_busy), MW'(0));

    run_frame(4, 3, 0, -1, -1);
    run_frame(4, 3, 1, -1, -1);
    run_frame(4, 3, 2, 5, -1);
    run_frame(4, 3, 0, -1, 5);
    run_frame(4, 3, 0, -1, -1);
    for (int k = 0; k < 6; k++) begin
      int w, h, st;
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 5);
      st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, w * h - 1)) : -1;
      run_frame(w, h, 2, st, -1);
    end
    budget_test();
    run_frame(1, 1, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
